// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 host transmitter: FSM state encoding,
// error codes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Command byte queue for the PS/2 transmitter: show-ahead synchronous FIFO.
// A push while full is dropped even if a pop happens in the same cycle.
module ps2_tx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wr_data,
    input  logic                       pop,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (cnt_q == (AW+1)'(DEPTH));
        empty    = (cnt_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = cnt_q;

endmodule

// File: rtl/ps2_host_tx_q.sv
// PS/2 host-to-device transmitter with command queue, timeout and ACK check.
// Optional PS2_TX_RETRY_EN: re-run a failed byte up to MAX_RETRY extra times.
module ps2_host_tx_q
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int SYNC_STAGES    = 2,
    parameter int MAX_RETRY      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          ps2_clk_i,
    output logic                          ps2_clk_oe,
    input  logic                          ps2_data_i,
    output logic                          ps2_data_oe,
    output logic                          busy,
    output logic                          sent,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                          TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_chk_retry
        $error("MAX_RETRY must fit the 2-bit retry counter");
    end

    logic [SYNC_STAGES-1:0] csync_q, csync_d;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic                   cprev_q;
    logic                   clk_s, data_s, fe;

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic          nack_q, nack_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          sent_q, sent_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    retry_q, retry_d;
`endif

    logic       pop, full, empty, in_frame, fail;
    logic [1:0] fail_code;
    logic [7:0] rd_data;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign clk_s  = csync_q[SYNC_STAGES-1];
    assign data_s = dsync_q[SYNC_STAGES-1];
    assign fe     = cprev_q & ~clk_s;

    always_comb begin
        csync_d   = {csync_q[SYNC_STAGES-2:0], ps2_clk_i};
        dsync_d   = {dsync_q[SYNC_STAGES-2:0], ps2_data_i};
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        sent_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = ERR_NONE;
        pop       = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        in_frame  = (state_q == ST_REQ) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP) ||
                    (state_q == ST_ACK);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Holding off while sent/err is showing spaces out frames.
                if (en && !empty && clk_s && data_s && !sent_q && !err_q) begin
                    pop      = 1'b1;
                    byte_d   = rd_data;
                    parity_d = odd_parity(rd_data);
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                clk_oe_d = 1'b0;
                if (fe) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fe) begin
                    data_oe_d = ~byte_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fe) begin
                    data_oe_d = ~parity_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fe) begin
                    data_oe_d = 1'b0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (fe) begin
                    nack_d  = data_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    if (!nack_q) begin
                        sent_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_frame && fe) cnt_d = '0;
        if (in_frame && cnt_q == TO_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end

        if (fail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            code_d    = fail_code;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < 2'(MAX_RETRY)) begin
                retry_d  = retry_q + 2'd1;
                clk_oe_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_INHIBIT;
                err_d    = 1'b0;
                code_d   = ERR_NONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csync_q   <= '1;
            dsync_q   <= '1;
            cprev_q   <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            csync_q   <= csync_d;
            dsync_q   <= dsync_d;
            cprev_q   <= clk_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
            code_q    <= code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign wr_ready    = !full;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != ST_IDLE);
    assign sent        = sent_q;
    assign err         = err_q;
    assign err_code    = code_q;

endmodule

// File: doc/ps2_host_tx_q.md
Name: ps2_host_tx_q

Overview:
Parametrised PS/2 host-to-device transmitter with a command byte queue, timeout detection and ACK checking. It queues bytes from the system side and runs the full host-request sequence on the open-drain PS/2 clock and data lines. It reports per-byte success or error. It sits beside the PS/2 receiver in the keyboard/mouse peripheral interface.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, ≥2)
INHIBIT_CYCLES, 10000, clk cycles ps2_clk is held low before a request (100 us at 100 MHz)
TIMEOUT_CYCLES, 1500000, max clk cycles between consecutive device clock falling edges, and from request to first edge (15 ms)
SYNC_STAGES, 2, synchroniser depth on ps2_clk_i/ps2_data_i
MAX_RETRY, 2, retry attempts per byte (used only with PS2_TX_RETRY_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  when low, no new frame is dequeued; a frame in flight completes
wr_valid  in  1  push request
wr_data  in  8  byte to send
wr_ready  out  1  queue not full
ps2_clk_i  in  1  PS/2 clock line sense
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_i  in  1  PS/2 data line sense
ps2_data_oe  out  1  1 = pull PS/2 data low
busy  out  1  FSM not in IDLE
sent  out  1  1-cycle pulse: byte ACKed
err  out  1  1-cycle pulse: byte failed
err_code  out  2  valid with err: 01 NACK, 10 timeout
level  out  $clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=0, async): all outputs 0 except wr_ready=1. Lines are released immediately (oe=0), the queue is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame silently.
- Push when wr_valid&&wr_ready. wr_ready = !full. There is no push-when-full, even if a pop happens in the same cycle. Simultaneous push and pop with the queue not full leaves level unchanged.
- Falling-edge detect: a synchronised ps2_clk 1→0 gives a 1-cycle fe strobe.
- FSM states:
  - IDLE: if en && !empty && synced clk=1 && synced data=1, pop the byte, compute odd parity (~^byte), go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES, then ps2_data_oe=1 (start bit) and go to REQ.
  - REQ: release clk (clk_oe=0), keep data_oe=1, wait for fe.
  - DATA: on each fe, drive bit k LSB-first (data_oe = ~bit). 8 bits, counter 0..7.
  - PARITY: on fe, drive parity.
  - STOP: on fe, release data.
  - ACK: on fe, sample data. Low means ACK, high means NACK.
  - WAIT_IDLE: wait for synced clk=1 && data=1. Then pulse sent (ACK) or err (NACK) and go to IDLE.
- Timeout: the counter restarts on entry to REQ and on every fe. Reaching TIMEOUT_CYCLES in REQ..ACK releases both lines, pulses err with code 10 and returns to IDLE.
- Latency: pop to clk_oe asserted is 1 cycle. Data changes 1 cycle after fe. sent/err fire 1 cycle after the lines are sensed idle.
- Back-to-back bytes: the next pop can occur no earlier than the cycle after sent/err.
- oe outputs are registered and glitch-free. The block never drives a line high.

Optional Feature:
PS2_TX_RETRY_EN:
- Defined: on NACK or timeout, the byte is held and the sequence restarts at INHIBIT, up to MAX_RETRY extra attempts. err fires only after the final attempt fails, with the last failure's code. A 2-bit retry_cnt is internal.
- Undefined: failure reports err immediately. MAX_RETRY is ignored and there is no retry logic.

Decomposition:
- Package ps2_pkg holds the FSM state encoding, the err_code constants (ERR_NACK=2'b01, ERR_TIMEOUT=2'b10), and the odd-parity function.
- One sub-module, ps2_tx_fifo: synchronous FIFO parametrised by FIFO_DEPTH, with full/empty/level outputs.
- Synchroniser and edge detect stay inline.

Test Plan:
- Push 0xED; model device clocks at 20 kHz and ACKs → clk_oe low ≥10000 cycles. Bits seen at rising edges are 0(start),1,0,1,1,0,1,1,1, parity 1, stop 1. Exactly one sent pulse; err stays 0.
- Push 0x01, then 0xFF back-to-back → parity 0 then 1. Two sent pulses in order; level goes 2→1→0.
- Device holds data high at the ACK edge → err=1, err_code=01, no sent. With PS2_TX_RETRY_EN: 3 INHIBIT phases, then a single err.
- Device never clocks after the request → after 1500000 cycles err with code 10 and both oe=0.
- Push 5 bytes with en=0, FIFO_DEPTH=4 → wr_ready=0 after the 4th, 5th byte dropped, level=4. Raise en: 4 frames are sent.
- Assert rst low during DATA bit 3 → ps2_clk_oe=ps2_data_oe=0 in the same cycle, level=0, busy=0. No sent or err pulse.
